// File: rtl/regex_axi_lite_slave_pkg.sv
// Shared definitions for the regex coprocessor AXI4-Lite register file.
// Holds the bus/register widths, command and status codes, register offsets,
// AXI response codes, channel FSM state types and the byte-strobe merge helper.
package regex_axi_lite_slave_pkg;

  localparam int unsigned REG_WIDTH      = 32;
  localparam int unsigned AXI_ADDR_WIDTH = 5;
  localparam int unsigned STRB_WIDTH     = REG_WIDTH / 8;

  // Commands consumed by the coprocessor control block
  localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_READ  = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_MATCH = 32'd3;
  localparam logic [REG_WIDTH-1:0] CMD_RESET = 32'd4;

  // Status codes reported by the coprocessor control block
  localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
  localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

  // Byte offsets of the register map
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_OFF_DATA_IN  = 5'h00;
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_OFF_ADDRESS  = 5'h04;
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_OFF_START_CC = 5'h08;
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_OFF_END_CC   = 5'h0C;
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_OFF_CMD      = 5'h10;
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_OFF_STATUS   = 5'h14;
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_OFF_DATA_O   = 5'h18;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} axi_wr_state_t;
  typedef enum logic       {RIdle, RValid}                 axi_rd_state_t;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [REG_WIDTH-1:0] apply_wstrb(input logic [REG_WIDTH-1:0]  old_val,
                                                       input logic [REG_WIDTH-1:0]  new_val,
                                                       input logic [STRB_WIDTH-1:0] strb);
    logic [REG_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regex_axi_lite_slave_if.sv
// AXI4-Lite bus bundle between the processing-system interconnect (master)
// and the regex coprocessor register file (slave). Carries the AW, W, B, AR
// and R channels; clock and reset travel separately.
interface regex_axi_lite_slave_if;
  import regex_axi_lite_slave_pkg::*;

  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [REG_WIDTH-1:0]      s_axi_wdata;
  logic [STRB_WIDTH-1:0]     s_axi_wstrb;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  logic [1:0]                s_axi_bresp;
  logic                      s_axi_bvalid;
  logic                      s_axi_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [REG_WIDTH-1:0]      s_axi_rdata;
  logic [1:0]                s_axi_rresp;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/regex_axi_lite_slave.sv
// AXI4-Lite slave register file in front of the regex coprocessor control block.
// Ports:
//   clk, rst              - single clock, synchronous active-high reset
//   axi                   - AXI4-Lite slave bus (AW/W/B/AR/R)
//   *_register outputs    - data_in, address, start/end CC pointer, cmd control registers
//   status_register,
//   data_o_register       - read-only values returned to software
// All valid/ready/resp/rdata outputs come straight from flops.
module regex_axi_lite_slave
  import regex_axi_lite_slave_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regex_axi_lite_slave_if.slave axi,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register
);

  axi_wr_state_t wr_state_q, wr_state_d;
  axi_rd_state_t rd_state_q, rd_state_d;

  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [REG_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;

  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [REG_WIDTH-1:0] rdata_q, rdata_d;

  logic [REG_WIDTH-1:0] data_in_q, data_in_d;
  logic [REG_WIDTH-1:0] address_q, address_d;
  logic [REG_WIDTH-1:0] start_cc_q, start_cc_d;
  logic [REG_WIDTH-1:0] end_cc_q, end_cc_d;
  logic [REG_WIDTH-1:0] cmd_q, cmd_d;

  logic                      aw_hs, w_hs, ar_hs;
  logic                      wr_go;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [REG_WIDTH-1:0]      wr_data;
  logic [STRB_WIDTH-1:0]     wr_strb;

  // Word-aligned decode: the byte offset within a word is irrelevant
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};

  assign aw_hs = axi.s_axi_awvalid & awready_q;
  assign w_hs  = axi.s_axi_wvalid & wready_q;
  assign ar_hs = axi.s_axi_arvalid & arready_q;

  // Write channel: latch AW and W independently, apply once both are held
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    data_in_d  = data_in_q;
    address_d  = address_q;
    start_cc_d = start_cc_q;
    end_cc_d   = end_cc_q;
    cmd_d      = cmd_q;
    wr_go      = 1'b0;
    wr_addr    = awaddr_q;
    wr_data    = wdata_q;
    wr_strb    = wstrb_q;

    unique case (wr_state_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          wr_go   = 1'b1;
          wr_addr = axi.s_axi_awaddr;
          wr_data = axi.s_axi_wdata;
          wr_strb = axi.s_axi_wstrb;
        end else if (aw_hs) begin
          awaddr_d   = axi.s_axi_awaddr;
          wr_state_d = WHaveAw;
        end else if (w_hs) begin
          wdata_d    = axi.s_axi_wdata;
          wstrb_d    = axi.s_axi_wstrb;
          wr_state_d = WHaveW;
        end
      end
      WHaveAw: begin
        if (w_hs) begin
          wr_go   = 1'b1;
          wr_data = axi.s_axi_wdata;
          wr_strb = axi.s_axi_wstrb;
        end
      end
      WHaveW: begin
        if (aw_hs) begin
          wr_go   = 1'b1;
          wr_addr = axi.s_axi_awaddr;
        end
      end
      WResp: begin
        if (axi.s_axi_bready) wr_state_d = WIdle;
      end
      default: wr_state_d = WIdle;
    endcase

    if (wr_go) begin
      wr_state_d = WResp;
      bresp_d    = AXI_RESP_OKAY;
      case ({wr_addr[AXI_ADDR_WIDTH-1:2], 2'b00})
        REG_OFF_DATA_IN:  data_in_d  = apply_wstrb(data_in_q, wr_data, wr_strb);
        REG_OFF_ADDRESS:  address_d  = apply_wstrb(address_q, wr_data, wr_strb);
        REG_OFF_START_CC: start_cc_d = apply_wstrb(start_cc_q, wr_data, wr_strb);
        REG_OFF_END_CC:   end_cc_d   = apply_wstrb(end_cc_q, wr_data, wr_strb);
        REG_OFF_CMD:      cmd_d      = apply_wstrb(cmd_q, wr_data, wr_strb);
        default:          bresp_d    = AXI_RESP_SLVERR;  // RO or unmapped
      endcase
    end

    awready_d = (wr_state_d == WIdle) || (wr_state_d == WHaveW);
    wready_d  = (wr_state_d == WIdle) || (wr_state_d == WHaveAw);
    bvalid_d  = (wr_state_d == WResp);
  end

  // Read channel: sources are sampled from current flops, so a same-cycle
  // write is not visible until the next read
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    unique case (rd_state_q)
      RIdle: begin
        if (ar_hs) begin
          rd_state_d = RValid;
          rresp_d    = AXI_RESP_OKAY;
          case ({axi.s_axi_araddr[AXI_ADDR_WIDTH-1:2], 2'b00})
            REG_OFF_DATA_IN:  rdata_d = data_in_q;
            REG_OFF_ADDRESS:  rdata_d = address_q;
            REG_OFF_START_CC: rdata_d = start_cc_q;
            REG_OFF_END_CC:   rdata_d = end_cc_q;
            REG_OFF_CMD:      rdata_d = cmd_q;
            REG_OFF_STATUS:   rdata_d = status_register;
            REG_OFF_DATA_O:   rdata_d = data_o_register;
            default: begin
              rdata_d = '0;
              rresp_d = AXI_RESP_SLVERR;
            end
          endcase
        end
      end
      RValid: begin
        if (axi.s_axi_rready) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase

    arready_d = (rd_state_d == RIdle);
    rvalid_d  = (rd_state_d == RValid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WIdle;
      rd_state_q <= RIdle;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXI_RESP_OKAY;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rresp_q    <= AXI_RESP_OKAY;
      rdata_q    <= '0;
      data_in_q  <= '0;
      address_q  <= '0;
      start_cc_q <= '0;
      end_cc_q   <= '0;
      cmd_q      <= CMD_NOP;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      data_in_q  <= data_in_d;
      address_q  <= address_d;
      start_cc_q <= start_cc_d;
      end_cc_q   <= end_cc_d;
      cmd_q      <= cmd_d;
    end
  end

  assign axi.s_axi_awready = awready_q;
  assign axi.s_axi_wready  = wready_q;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.s_axi_rdata   = rdata_q;

  assign data_in_register          = data_in_q;
  assign address_register          = address_q;
  assign start_cc_pointer_register = start_cc_q;
  assign end_cc_pointer_register   = end_cc_q;
  assign cmd_register              = cmd_q;

endmodule

// File: tb/tb_regex_axi_lite_slave.sv
// Bench for regex_axi_lite_slave: directed scenarios plus randomized reads and
// writes, checked against a register-array model of the register map.
module tb_regex_axi_lite_slave;
  import regex_axi_lite_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in_r, address_r, start_cc_r, end_cc_r, cmd_r;
  logic [31:0] status_reg, data_o_reg;

  regex_axi_lite_slave_if axi ();

  regex_axi_lite_slave dut (
    .clk                       (clk),
    .rst                       (rst),
    .axi                       (axi),
    .data_in_register          (data_in_r),
    .address_register          (address_r),
    .start_cc_pointer_register (start_cc_r),
    .end_cc_pointer_register   (end_cc_r),
    .cmd_register              (cmd_r),
    .status_register           (status_reg),
    .data_o_register           (data_o_reg)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;
  logic [31:0] mdl_regs [5];  // data_in, address, start_cc, end_cc, cmd

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Control outputs must track the model on every cycle outside reset
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ({data_in_r, address_r, start_cc_r, end_cc_r, cmd_r} !==
          {mdl_regs[0], mdl_regs[1], mdl_regs[2], mdl_regs[3], mdl_regs[4]}) begin
        n_fail++;
        $display("FAIL ctrl_regs: got %h %h %h %h %h, expected %h %h %h %h %h at %0t",
                 data_in_r, address_r, start_cc_r, end_cc_r, cmd_r,
                 mdl_regs[0], mdl_regs[1], mdl_regs[2], mdl_regs[3], mdl_regs[4], $time);
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic void model_read(input logic [4:0] a, output logic [31:0] d,
                                     output logic [1:0] r);
    int idx;
    idx = int'(a[4:2]);
    r   = 2'b00;
    if (idx < 5)       d = mdl_regs[idx];
    else if (idx == 5) d = status_reg;
    else if (idx == 6) d = data_o_reg;
    else begin
      d = 32'h0;
      r = 2'b10;
    end
  endfunction

  // Called #1 after an edge. lead > 0: W leads AW by lead cycles; lead < 0: AW leads.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int bdly, output logic [1:0] resp);
    int          aw_at, w_at, c, idx;
    bit          aw_done, w_done, hs_aw, hs_w;
    logic [1:0]  exp_resp;
    aw_at   = (lead > 0) ? lead : 0;
    w_at    = (lead < 0) ? -lead : 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    c       = 0;
    resp    = 2'bxx;
    while (!(aw_done && w_done) && c < 40) begin
      axi.s_axi_awaddr  = addr;
      axi.s_axi_awvalid = !aw_done && (c >= aw_at);
      axi.s_axi_wdata   = data;
      axi.s_axi_wstrb   = strb;
      axi.s_axi_wvalid  = !w_done && (c >= w_at);
      if (w_done && !aw_done) check("wready_low_holding_w", 32'(axi.s_axi_wready), 32'd0);
      if (aw_done && !w_done) check("awready_low_holding_aw", 32'(axi.s_axi_awready), 32'd0);
      hs_aw = axi.s_axi_awvalid && axi.s_axi_awready;
      hs_w  = axi.s_axi_wvalid && axi.s_axi_wready;
      @(posedge clk);
      #1;
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      c++;
    end
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    idx = int'(addr[4:2]);
    if (idx < 5) begin
      mdl_regs[idx] = merge(mdl_regs[idx], data, strb);
      exp_resp = 2'b00;
    end else begin
      exp_resp = 2'b10;
    end
    check("bvalid_at_t1", 32'(axi.s_axi_bvalid), 32'd1);
    check("bresp", 32'(axi.s_axi_bresp), 32'(exp_resp));
    resp = axi.s_axi_bresp;
    for (int i = 0; i < bdly; i++) begin
      @(posedge clk);
      #1;
      check("bvalid_held", 32'(axi.s_axi_bvalid), 32'd1);
      check("awready_low_in_resp", 32'(axi.s_axi_awready), 32'd0);
    end
    axi.s_axi_bready = 1'b1;
    @(posedge clk);
    #1;
    axi.s_axi_bready = 1'b0;
    check("bvalid_cleared", 32'(axi.s_axi_bvalid), 32'd0);
    check("awready_after_b", 32'(axi.s_axi_awready), 32'd1);
  endtask

  // Called #1 after an edge; wiggle randomizes the RO sources while R is held
  task automatic do_read(input logic [4:0] addr, input int rdly, input bit wiggle,
                         output logic [31:0] data, output logic [1:0] resp);
    int          c;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    c    = 0;
    data = 32'hx;
    resp = 2'bxx;
    axi.s_axi_araddr  = addr;
    axi.s_axi_arvalid = 1'b1;
    while (!axi.s_axi_arready && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!axi.s_axi_arready) begin
      axi.s_axi_arvalid = 1'b0;
      check("read_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    model_read(addr, exp_d, exp_r);
    @(posedge clk);
    #1;
    axi.s_axi_arvalid = 1'b0;
    check("rvalid_at_t1", 32'(axi.s_axi_rvalid), 32'd1);
    check("rdata", axi.s_axi_rdata, exp_d);
    check("rresp", 32'(axi.s_axi_rresp), 32'(exp_r));
    for (int i = 0; i < rdly; i++) begin
      if (wiggle) begin
        status_reg = $urandom;
        data_o_reg = $urandom;
      end
      @(posedge clk);
      #1;
      check("rvalid_held", 32'(axi.s_axi_rvalid), 32'd1);
      check("rdata_stable", axi.s_axi_rdata, exp_d);
    end
    data = axi.s_axi_rdata;
    resp = axi.s_axi_rresp;
    axi.s_axi_rready = 1'b1;
    @(posedge clk);
    #1;
    axi.s_axi_rready = 1'b0;
    check("rvalid_cleared", 32'(axi.s_axi_rvalid), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_awready"}, 32'(axi.s_axi_awready), 32'd1);
    check({tag, "_wready"}, 32'(axi.s_axi_wready), 32'd1);
    check({tag, "_arready"}, 32'(axi.s_axi_arready), 32'd1);
    check({tag, "_bvalid"}, 32'(axi.s_axi_bvalid), 32'd0);
    check({tag, "_rvalid"}, 32'(axi.s_axi_rvalid), 32'd0);
    check({tag, "_rdata"}, axi.s_axi_rdata, 32'd0);
    check({tag, "_resps"}, {28'd0, axi.s_axi_bresp, axi.s_axi_rresp}, 32'd0);
    check({tag, "_cmd"}, cmd_r, CMD_NOP);
    check({tag, "_ctrl_or"}, data_in_r | address_r | start_cc_r | end_cc_r, 32'd0);
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mdl_regs[i] = 32'h0;
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [4:0]  a;
    int          op;
    rst               = 1'b1;
    axi.s_axi_awaddr  = '0;
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata   = '0;
    axi.s_axi_wstrb   = '0;
    axi.s_axi_wvalid  = 1'b0;
    axi.s_axi_bready  = 1'b0;
    axi.s_axi_araddr  = '0;
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b0;
    status_reg        = STATUS_IDLE;
    data_o_reg        = 32'h0;
    for (int i = 0; i < 5; i++) mdl_regs[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    apply_reset();
    reset_checks("reset");

    // cmd reads back as NOP after reset
    do_read(5'h10, 0, 1'b0, d, r);
    check("cmd_after_reset", d, 32'h0);
    check("cmd_after_reset_resp", 32'(r), 32'd0);

    // Byte-strobed write with AW and W together
    do_write(5'h04, 32'hDEADBEEF, 4'b0101, 0, 0, r);
    check("address_strobed", address_r, 32'h00AD00EF);
    check("address_strobed_resp", 32'(r), 32'd0);

    // W three cycles ahead of AW, B back-pressured four cycles
    do_write(5'h00, 32'h12, 4'hF, 3, 4, r);
    check("data_in_w_first", data_in_r, 32'h12);

    // RO write and unmapped read
    do_write(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, r);
    check("write_ro_slverr", 32'(r), 32'd2);
    do_read(5'h1C, 0, 1'b0, d, r);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", 32'(r), 32'd2);

    // Status sampled on the AR handshake, held until rready
    status_reg = STATUS_RUNNING;
    fork
      do_read(5'h14, 3, 1'b0, d, r);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        status_reg = STATUS_ACCEPTED;
      end
    join
    check("status_held", d, STATUS_RUNNING);

    // Same-cycle write and read of start_cc: read sees the old value
    fork
      do_write(5'h08, 32'h5, 4'hF, 0, 0, r);
      do_read(5'h08, 0, 1'b0, d, r);
    join
    check("same_cycle_old_value", d, 32'h0);
    do_read(5'h08, 0, 1'b0, d, r);
    check("start_cc_new_value", d, 32'h5);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      op         = int'($urandom_range(2, 0));
      a          = 5'($urandom_range(31, 0));
      status_reg = $urandom;
      data_o_reg = $urandom;
      case (op)
        0: do_write(a, $urandom, 4'($urandom_range(15, 0)), int'($urandom_range(6, 0)) - 3,
                    int'($urandom_range(3, 0)), r);
        1: do_read(a, int'($urandom_range(3, 0)), 1'b1, d, r);
        default: begin
          fork
            do_write(a, $urandom, 4'($urandom_range(15, 0)), int'($urandom_range(4, 0)) - 2,
                     int'($urandom_range(2, 0)), r);
            do_read(5'($urandom_range(31, 0)), int'($urandom_range(2, 0)), 1'b0, d, r);
          join
        end
      endcase
    end

    // Reset while a lone W is held: abandoned silently
    axi.s_axi_wdata  = 32'hCAFE;
    axi.s_axi_wstrb  = 4'hF;
    axi.s_axi_wvalid = 1'b1;
    @(posedge clk);
    #1;
    axi.s_axi_wvalid = 1'b0;
    apply_reset();
    reset_checks("rst_have_w");

    // Reset while B is pending
    axi.s_axi_awaddr  = 5'h10;
    axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wdata   = 32'hA5;
    axi.s_axi_wstrb   = 4'hF;
    axi.s_axi_wvalid  = 1'b1;
    @(posedge clk);
    #1;
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    mdl_regs[4]       = 32'hA5;
    check("bvalid_before_rst", 32'(axi.s_axi_bvalid), 32'd1);
    check("cmd_before_rst", cmd_r, 32'hA5);
    apply_reset();
    reset_checks("rst_in_resp");

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regex_axi_lite_slave.md
# regex_axi_lite_slave

AXI4-Lite slave register file that sits directly upstream of the coprocessor control block. It turns software bus transactions into the control registers that block consumes: data_in, address, start/end CC pointers and command. It also returns that block's status and data-out registers to software. It is the only bus-facing logic between the processing-system interconnect and the regex coprocessor.

## Interface
Parameters:
- REG_WIDTH, 32 (from AXI_package): data width of the bus and of every register.
- AXI_ADDR_WIDTH, 5: byte address width; decodes 8 word slots.

Ports (all AXI channels use s_axi_ prefix):
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  REG_WIDTH  write data.
- s_axi_wstrb  in  REG_WIDTH/8  byte enables.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  REG_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- data_in_register, address_register, start_cc_pointer_register, end_cc_pointer_register, cmd_register  out  REG_WIDTH  registered control outputs to the coprocessor control block.
- status_register, data_o_register  in  REG_WIDTH  read-only values from the coprocessor control block.

## Operation
- Register map (byte offsets; addr[1:0] ignored):
  - 0x00 data_in RW
  - 0x04 address RW
  - 0x08 start_cc_pointer RW
  - 0x0C end_cc_pointer RW
  - 0x10 cmd RW
  - 0x14 status RO
  - 0x18 data_o RO
  - 0x1C unmapped
- Write channel FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready is high in W_IDLE and W_HAVE_W; wready is high in W_IDLE and W_HAVE_AW.
  - The address and data are each latched on their own handshake. AW and W may arrive in either order or in the same cycle.
  - Once both are held, the write is applied in that same cycle, and the FSM enters W_RESP with bvalid=1.
  - W_RESP holds bvalid until bready, then returns to W_IDLE. Only one write is outstanding at a time.
- Write application: each byte lane i is updated only when wstrb[i]=1.
  - Writes to RO or unmapped offsets change nothing and return bresp=SLVERR (2'b10).
  - All other writes return OKAY (2'b00).
- Read channel FSM states: R_IDLE, R_VALID.
  - arready=1 only in R_IDLE.
  - On the AR handshake, rdata/rresp are registered from the decoded source, and the FSM enters R_VALID (rvalid=1).
  - rdata and rresp stay stable until rready, then the FSM returns to R_IDLE.
  - Unmapped reads return 0 with rresp=SLVERR.
  - status and data_o are sampled on the handshake cycle. data_o depends combinationally on cmd/address downstream, so software sets those first.
- cmd_register holds the last written value; it does not self-clear. Software writes CMD_NOP to end a sequence. CMD_RESET is acted on downstream, not here.
- Read and write channels are independent and may complete in the same cycle. A read of a register being written in the same cycle returns the pre-write value.

## Timing
- Reset (synchronous, rst=1 at an edge):
  - All control outputs are 0, and cmd_register=CMD_NOP.
  - bvalid=0, rvalid=0, rdata=0, bresp=rresp=OKAY.
  - Both FSMs go to IDLE, with awready=wready=arready=1 from the first post-reset cycle.
  - A reset mid-transaction abandons it with no response.
- AW and W both accepted at edge T: the register output changes at T+1, and bvalid=1 from T+1.
- Write throughput: 2 cycles per write with bready held high.
- AR accepted at edge T: rvalid=1 and rdata valid from T+1.
- Read throughput: 1 read per 2 cycles with rready held high.
- Valid, ready and resp outputs are all driven directly from flops.

## Structure
- AXI_package holds:
  - REG_WIDTH and the CMD_*/STATUS_* constants.
  - The offset localparams (REG_OFF_DATA_IN … REG_OFF_DATA_O).
  - AXI_RESP_OKAY and AXI_RESP_SLVERR.
  - The enums axi_wr_state_t and axi_rd_state_t.
- No sub-module is needed. The byte-strobe merge is a function in the package: apply_wstrb(old, new, strb).

## Test plan
- Reset, then read 0x10 -> rdata=CMD_NOP, rresp=OKAY, rvalid one cycle after the AR handshake.
- AW to 0x04 with W=0xDEADBEEF and wstrb=4'b0101, AW and W in the same cycle -> address_register=0x00AD00EF at T+1, bresp=OKAY.
- W presented 3 cycles before AW (data 0x12, offset 0x00), bready held low for 4 cycles -> data_in=0x12; bvalid held for 4 cycles; no second awready until B completes.
- Write to 0x14 -> bresp=SLVERR, status source unchanged. Read 0x1C -> rdata=0, rresp=SLVERR.
- Drive status_register=STATUS_RUNNING and read 0x14 with rready held low for 3 cycles while status changes to STATUS_ACCEPTED -> rdata stays STATUS_RUNNING until rready.
- Simultaneous write of 0x5 to 0x08 and read of 0x08 -> read returns the old value; a following read returns 0x5. Then assert rst mid-write -> bvalid=0 and all outputs at reset values.
